// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: angle format, quadrant boundaries in Q16.4 degrees,
// and the phase-sweep FSM state encoding.
package cordic_pkg;
    localparam int ANGLE_W      = 20;
    localparam int FRAC_W       = 4;
    localparam int FULL_TURN_Q4 = 5760;
    localparam int QUAD_90_Q4   = 1440;
    localparam int QUAD_180_Q4  = 2880;
    localparam int QUAD_270_Q4  = 4320;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        FLUSH = ST_FLUSH
    } cps_state_t;
endpackage

// File: rtl/cordic_phase_sweep_valid_delay.sv
// cps_valid_delay: LAT-deep shift register with synchronous clear; aligns the
// angle qualifier with the downstream core's registered results.
module cps_valid_delay
    import cordic_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout
);
    logic [LAT-1:0] sr_reg;

    always_ff @(posedge clk) begin
        if (clr) sr_reg[0] <= 1'b0;
        else     sr_reg[0] <= din;
    end

    generate
        for (genvar gi = 1; gi < LAT; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (clr) sr_reg[gi] <= 1'b0;
                else     sr_reg[gi] <= sr_reg[gi-1];
            end
        end
    endgenerate

    assign dout = sr_reg[LAT-1];
endmodule

// File: rtl/cordic_phase_sweep.sv
// Angle sequencer feeding the CORDIC core: steps target_angle modulo 360 deg.
// Optional start phase input enabled by CPS_PHASE_OFFSET_EN.
module cordic_phase_sweep
    import cordic_pkg::*;
#(
    parameter int ANGLE_W    = cordic_pkg::ANGLE_W,
    parameter int FULL_TURN  = cordic_pkg::FULL_TURN_Q4,
    parameter int CORDIC_LAT = 1,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [ANGLE_W-1:0] step,
    input  logic [CNT_W-1:0]   num_samples,
`ifdef CPS_PHASE_OFFSET_EN
    input  logic [ANGLE_W-1:0] phase_offset,
`endif
    output logic [ANGLE_W-1:0] target_angle,
    output logic               angle_valid,
    output logic               res_valid,
    output logic               busy,
    output logic               done,
    output logic               step_err
);
    localparam logic [ANGLE_W:0] FT_W = (ANGLE_W+1)'(FULL_TURN);
    localparam int               FL_W = $clog2(CORDIC_LAT + 1);
    localparam logic [FL_W-1:0]  LAT_C = FL_W'(CORDIC_LAT);

    cps_state_t         state_reg;
    logic [ANGLE_W-1:0] acc_reg, step_reg, target_reg;
    logic [CNT_W-1:0]   num_reg, cnt_reg;
    logic [FL_W-1:0]    flush_cnt_reg;
    logic               angle_valid_reg, done_reg, step_err_reg;
    logic [ANGLE_W-1:0] start_phase;
    logic               illegal;

    // Both operands are below FULL_TURN, so one conditional subtract suffices.
    function automatic logic [ANGLE_W-1:0] mod_add(input logic [ANGLE_W-1:0] a,
                                                   input logic [ANGLE_W-1:0] b);
        logic [ANGLE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= FT_W) sum = sum - FT_W;
        return sum[ANGLE_W-1:0];
    endfunction

    always_comb begin
        illegal = (step == '0) || ({1'b0, step} >= FT_W);
`ifdef CPS_PHASE_OFFSET_EN
        start_phase = phase_offset;
        illegal     = illegal || ({1'b0, phase_offset} >= FT_W);
`else
        start_phase = '0;
`endif
    end

    // acc_reg always holds the angle to be emitted on the next RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            acc_reg         <= '0;
            step_reg        <= '0;
            num_reg         <= '0;
            cnt_reg         <= '0;
            flush_cnt_reg   <= '0;
            target_reg      <= '0;
            angle_valid_reg <= 1'b0;
            done_reg        <= 1'b0;
            step_err_reg    <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            step_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !stop) begin
                        if (illegal) begin
                            step_err_reg <= 1'b1;
                        end else begin
                            step_reg        <= step;
                            num_reg         <= num_samples;
                            target_reg      <= start_phase;
                            acc_reg         <= mod_add(start_phase, step);
                            cnt_reg         <= CNT_W'(1);
                            angle_valid_reg <= 1'b1;
                            state_reg       <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (stop || (num_reg != '0 && cnt_reg == num_reg)) begin
                        angle_valid_reg <= 1'b0;
                        target_reg      <= '0;
                        flush_cnt_reg   <= FL_W'(1);
                        done_reg        <= (CORDIC_LAT == 1);
                        state_reg       <= FLUSH;
                    end else begin
                        target_reg <= acc_reg;
                        acc_reg    <= mod_add(acc_reg, step_reg);
                        cnt_reg    <= cnt_reg + CNT_W'(1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt_reg == LAT_C) begin
                        state_reg <= IDLE;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg + FL_W'(1);
                        done_reg      <= (flush_cnt_reg + FL_W'(1) == LAT_C);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    cps_valid_delay #(.LAT(CORDIC_LAT)) u_valid_delay (
        .clk  (clk),
        .clr  (rst),
        .din  (angle_valid_reg),
        .dout (res_valid)
    );

    assign target_angle = target_reg;
    assign angle_valid  = angle_valid_reg;
    assign busy         = (state_reg != IDLE);
    assign done         = done_reg;
    assign step_err     = step_err_reg;
endmodule

// File: tb/tb_cordic_phase_sweep.sv
// Directed bench for cordic_phase_sweep; expected angle sequences are hand-computed.
// Offset vectors run only when CPS_PHASE_OFFSET_EN is defined.
module tb_cordic_phase_sweep;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [19:0] step = '0;
    logic [15:0] num_samples = '0;
    logic [19:0] phase_offset = '0;
    logic [19:0] target_angle;
    logic        angle_valid, res_valid, busy, done, step_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cordic_phase_sweep dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .step         (step),
        .num_samples  (num_samples),
`ifdef CPS_PHASE_OFFSET_EN
        .phase_offset (phase_offset),
`endif
        .target_angle (target_angle),
        .angle_valid  (angle_valid),
        .res_valid    (res_valid),
        .busy         (busy),
        .done         (done),
        .step_err     (step_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " target"}, 32'(target_angle), 0);
        check({tag, " angle_valid"}, 32'(angle_valid), 0);
        check({tag, " res_valid"}, 32'(res_valid), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " step_err"}, 32'(step_err), 0);
    endtask

    // Called at a negedge with the FSM in IDLE; returns at the IDLE cycle after done.
    task automatic sweep(input string name, input int stp, input int num,
                         input int stop_after, input int n_exp, input int exp[8]);
        int  vc = 0, rc = 0, dc = 0;
        int  first_v = -1, first_r = -1, last_r = -1, done_cyc = -1;
        bit  fin = 0;
        step = 20'(stp);
        num_samples = 16'(num);
        start = 1'b1;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            if (angle_valid) begin
                if (first_v < 0) first_v = c;
                if (vc < n_exp) check($sformatf("%s angle[%0d]", name, vc), 32'(target_angle), exp[vc]);
                vc++;
                if (stop_after != 0 && vc == stop_after) stop = 1'b1;
            end
            if (res_valid) begin
                if (first_r < 0) first_r = c;
                last_r = c;
                rc++;
            end
            if (done) begin
                dc++;
                done_cyc = c;
            end
            if (dc > 0 && c > done_cyc) fin = 1;
        end
        check({name, " finished"}, 32'(fin), 1);
        check({name, " first_valid_cycle"}, 32'(first_v), 0);
        check({name, " n_valid"}, 32'(vc), 32'(n_exp));
        check({name, " n_res_valid"}, 32'(rc), 32'(n_exp));
        check({name, " res_lag"}, 32'(first_r - first_v), 1);
        check({name, " n_done"}, 32'(dc), 1);
        check({name, " done_on_last_res"}, 32'(done_cyc), 32'(last_r));
        check({name, " busy_after"}, 32'(busy), 0);
    endtask

    task automatic bad_start(input string name, input int stp, input bit with_stop, input int exp_err);
        step = 20'(stp);
        num_samples = 16'd4;
        start = 1'b1;
        stop = with_stop;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        check({name, " step_err"}, 32'(step_err), 32'(exp_err));
        check({name, " busy"}, 32'(busy), 0);
        check({name, " angle_valid"}, 32'(angle_valid), 0);
        @(negedge clk);
        check({name, " step_err_cleared"}, 32'(step_err), 0);
        check({name, " busy_later"}, 32'(busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        sweep("step16",   16,   4, 0, 4, '{0, 16, 32, 48, 0, 0, 0, 0});
        sweep("step1440", 1440, 6, 0, 6, '{0, 1440, 2880, 4320, 0, 1440, 0, 0});
        sweep("step5000", 5000, 3, 0, 3, '{0, 5000, 4240, 0, 0, 0, 0, 0});

        bad_start("step0",      0,    1'b0, 1);
        bad_start("step5760",   5760, 1'b0, 1);
        bad_start("step5759_ok_stop", 5759, 1'b1, 0);
        bad_start("stop_wins_illegal", 0, 1'b1, 0);

        sweep("stop3", 32, 0, 3, 3, '{0, 32, 64, 0, 0, 0, 0, 0});
        sweep("max_step", 5759, 3, 0, 3, '{0, 5759, 5758, 0, 0, 0, 0, 0});

        // Reset asserted during the second RUN cycle.
        step = 20'd16;
        num_samples = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_mid run1 angle", 32'(target_angle), 0);
        @(negedge clk);
        check("rst_mid run2 angle", 32'(target_angle), 16);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_mid");
        rst = 1'b0;
        sweep("after_rst", 16, 2, 0, 2, '{0, 16, 0, 0, 0, 0, 0, 0});

`ifdef CPS_PHASE_OFFSET_EN
        phase_offset = 20'd2880;
        sweep("offset2880", 2880, 3, 0, 3, '{2880, 0, 2880, 0, 0, 0, 0, 0});
        phase_offset = 20'd5760;
        bad_start("offset5760", 16, 1'b0, 1);
        phase_offset = 20'd0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
